des_key_schedule: RTL and testbench
===================================

Name: des_key_schedule

Overview:
- Generates the sixteen 48-bit DES round subkeys from a 64-bit key and presents them one per handshake on the `key_dat` side of the Round datapath.
- Supports encrypt order (K1..K16, left rotations) and decrypt order (K16..K1, right rotations), computed on the fly with no subkey storage.
- Sits between the key register and the round iteration controller, which consumes one subkey per accepted transfer.

Parameters:
- none (DES-fixed: 16 rounds, PC-1, PC-2 and the shift table are hard-coded)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to load `key_in` and begin a schedule; ignored unless IDLE
- key_in  in  64  DES key; key_in[63] = DES bit 1; parity bits (8,16,...,64) ignored
- decrypt  in  1  sampled with `start`; 0 = K1..K16, 1 = K16..K1
- key_ready  in  1  consumer accepts `key_out` this cycle
- key_valid  out  1  `key_out` holds a valid subkey
- key_out  out  48  current subkey; key_out[47] = subkey bit 1
- round_idx  out  4  DES round number minus 1 of `key_out` (K1 = 0, K16 = 15)
- busy  out  1  high from the cycle after accepted start until return to IDLE
- done  out  1  one-cycle pulse after the 16th subkey is accepted

Behaviour:
- Reset (rst = 1 at a clock edge) forces the following, regardless of state, including mid-schedule:
  - state = IDLE
  - key_valid = 0, key_out = 0, round_idx = 0, busy = 0, done = 0
  - C/D registers cleared
- States:
  - IDLE: on start, apply PC-1 to key_in giving C0 (28 bits) and D0 (28 bits).
    - Encrypt: register C1/D1 = C0/D0 each rotated left 1.
    - Decrypt: register C/D = C0/D0 unrotated (C16 = C0).
    - Latch mode, go to EMIT.
  - EMIT:
    - key_valid = 1.
    - key_out = PC-2 of the registered C/D; combinational from the registers, stable while key_valid=1 and key_ready=0.
    - On key_valid & key_ready with fewer than 16 subkeys accepted: rotate C/D for the next subkey and step round_idx (+1 encrypt, -1 decrypt).
    - On the 16th accept: go to DONE.
  - DONE: key_valid = 0, done = 1 for exactly one cycle, busy = 0 from the next cycle, go to IDLE.
- Latency:
  - start sampled at edge N → key_valid = 1 in cycle N+1.
  - With key_ready held high, 16 subkeys appear in 16 consecutive cycles; done is asserted in cycle N+17.
- Shift rules:
  - Encrypt left-rotate amounts before K1..K16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt right-rotate amounts, applied in output order before K16,K15,...,K1: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - C and D rotate independently within 28 bits; total rotation over a schedule is 28, so C/D wrap back to C0/D0.
- round_idx:
  - Encrypt starts at 0, decrypt starts at 15.
  - No wrap-around is observable: the state leaves EMIT before a 17th step.
- Handshake and boundary cases:
  - Backpressure: key_ready low holds key_out, round_idx and C/D unchanged for any number of cycles.
  - start while busy/EMIT/DONE is ignored; key_in and decrypt changes after the start cycle have no effect.
  - start in the same cycle as rst: rst wins, block stays IDLE.
  - key_ready while key_valid = 0 has no effect.

Test Plan:
- Encrypt: key_in=64'h133457799BBCDFF1, decrypt=0, start pulse, key_ready=1 → key_valid in next cycle; first key_out=48'h1B02EFFC7072 (round_idx 0), second 48'h79AED9DBC9E5 (round_idx 1), 16th 48'hCB3D8B0E17F5 (round_idx 15); done pulses one cycle later; busy falls.
- Decrypt: same key, decrypt=1 → first key_out=48'hCB3D8B0E17F5 (round_idx 15), last 48'h1B02EFFC7072 (round_idx 0); the sequence equals the encrypt sequence reversed.
- Backpressure: encrypt run with key_ready low for 5 cycles after K1 → key_out stays 48'h1B02EFFC7072 with round_idx 0; release → K2 next; total 16 accepts then done.
- Ignored start: pulse start with key_in=64'h0 during round 5 of a run → remaining subkeys match the original key's schedule.
- Reset mid-operation: assert rst at round_idx 7 → next cycle key_valid=0, busy=0, key_out=0; a new start produces K1=48'h1B02EFFC7072 correctly.
- Parity independence: key_in=64'h123456789ABCDEF0 vs the same key with every byte's LSB inverted → identical 16-subkey sequences.

Source files
------------

// File: rtl/des_key_schedule.sv
// DES key schedule: expands a 64-bit key into the sixteen 48-bit round subkeys,
// streamed one per valid/ready handshake in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        key_ready,
    output logic        key_valid,
    output logic [47:0] key_out,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_DONE
    } state_t;

    // Permuted choice tables, 1-based DES bit numbers (bit 1 is the MSB).
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    state_t      state;
    state_t      state_next;
    logic [27:0] c_reg;
    logic [27:0] d_reg;
    logic        mode_dec;
    logic [55:0] cd_init;
    logic        accept;
    logic        last_round;
    logic        parity_unused;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[55 - i] = k[64 - PC1_TAB[i]];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 48; j++) begin
            r[47 - j] = cd[56 - PC2_TAB[j]];
        end
        return r;
    endfunction

    // Encrypt shift applied before round idx+1; only K1, K2, K9 and K16 use a single step.
    function automatic logic [1:0] enc_shift(input logic [3:0] idx);
        logic [1:0] s;
        if (idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15) begin
            s = 2'd1;
        end else begin
            s = 2'd2;
        end
        return s;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] v, input logic [1:0] n);
        logic [27:0] r;
        case (n)
            2'd1:    r = {v[26:0], v[27]};
            2'd2:    r = {v[25:0], v[27:26]};
            default: r = v;
        endcase
        return r;
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] v, input logic [1:0] n);
        logic [27:0] r;
        case (n)
            2'd1:    r = {v[0], v[27:1]};
            2'd2:    r = {v[1:0], v[27:2]};
            default: r = v;
        endcase
        return r;
    endfunction

    assign cd_init = pc1(key_in);

    // Parity bits play no part in the schedule.
    assign parity_unused = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8],  key_in[0]};

    assign accept     = (state == ST_EMIT) && key_ready;
    assign last_round = mode_dec ? (round_idx == 4'd0) : (round_idx == 4'd15);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (accept && last_round) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        key_valid = (state == ST_EMIT);
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        key_out   = key_valid ? pc2({c_reg, d_reg}) : 48'd0;
    end

    // Decrypt walks backwards: undo the encrypt shift that produced the current round.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_reg     <= '0;
            d_reg     <= '0;
            round_idx <= '0;
            mode_dec  <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            mode_dec <= decrypt;
            if (decrypt) begin
                c_reg     <= cd_init[55:28];
                d_reg     <= cd_init[27:0];
                round_idx <= 4'd15;
            end else begin
                c_reg     <= rotl(cd_init[55:28], 2'd1);
                d_reg     <= rotl(cd_init[27:0], 2'd1);
                round_idx <= 4'd0;
            end
        end else if (accept && !last_round) begin
            if (mode_dec) begin
                c_reg     <= rotr(c_reg, enc_shift(round_idx));
                d_reg     <= rotr(d_reg, enc_shift(round_idx));
                round_idx <= round_idx - 4'd1;
            end else begin
                c_reg     <= rotl(c_reg, enc_shift(round_idx + 4'd1));
                d_reg     <= rotl(d_reg, enc_shift(round_idx + 4'd1));
                round_idx <= round_idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: expected subkeys come from a bit-level DES
// reference model using cumulative rotation amounts.
module tb_des_key_schedule;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] key_in;
    logic        decrypt;
    logic        key_ready;
    logic        key_valid;
    logic [47:0] key_out;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [47:0] key;
        logic [3:0]  idx;
    } exp_t;

    exp_t sb_q[$];

    localparam logic [63:0] KNOWN_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] PAR_KEY   = 64'h123456789ABCDEF0;

    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                  10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                                  23,19,12,4,26,8, 16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48,
                                  44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    des_key_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .decrypt   (decrypt),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .key_out   (key_out),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Subkey k (1..16): C0/D0 rotated left by the sum of the first k shift amounts.
    function automatic logic [47:0] model_subkey(input logic [63:0] key, input int k);
        bit kb [64];
        bit c0 [28];
        bit d0 [28];
        bit cd [56];
        int tot;
        logic [47:0] res;
        for (int i = 0; i < 64; i++) kb[i] = key[63 - i];
        for (int i = 0; i < 28; i++) begin
            c0[i] = kb[PC1_T[i] - 1];
            d0[i] = kb[PC1_T[i + 28] - 1];
        end
        tot = 0;
        for (int j = 0; j < k; j++) tot += SHIFT_T[j];
        for (int i = 0; i < 28; i++) begin
            cd[i]      = c0[(i + tot) % 28];
            cd[i + 28] = d0[(i + tot) % 28];
        end
        res = '0;
        for (int j = 0; j < 48; j++) res[47 - j] = cd[PC2_T[j] - 1];
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented subkey while the consumer is ready pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (key_valid && key_ready) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_subkey", {16'd0, key_out}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("key_out", {16'd0, key_out}, {16'd0, e.key});
                checkOutput("round_idx", {60'd0, round_idx}, {60'd0, e.idx});
            end
        end
        if (done) begin
            checkOutput("sb_drained_at_done", sb_q.size(), 0);
        end
    end

    // Issues a start pulse and queues the expected subkey stream in output order.
    task automatic applyStimulus(input logic [63:0] key, input logic dec, input bit use_known);
        exp_t e;
        key_in  = key;
        decrypt = dec;
        start   = 1'b1;
        for (int n = 0; n < 16; n++) begin
            int r;
            r = dec ? 15 - n : n;
            e.idx = 4'(r);
            e.key = model_subkey(key, r + 1);
            if (use_known && r == 0)  e.key = 48'h1B02EFFC7072;
            if (use_known && r == 1)  e.key = 48'h79AED9DBC9E5;
            if (use_known && r == 15) e.key = 48'hCB3D8B0E17F5;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        start   = 1'b0;
        key_in  = {$urandom, $urandom};
        decrypt = 1'($urandom_range(1));
        checkOutput("valid_after_start", {63'd0, key_valid}, 64'd1);
        checkOutput("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_done(input int ready_pct, output int cycles);
        bit got;
        got    = 0;
        cycles = 0;
        while (!got && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
            if (done) got = 1;
            else key_ready = ($urandom_range(99) < ready_pct);
        end
        if (!got) begin
            checkOutput("done_timeout", 64'd0, 64'd1);
        end else begin
            checkOutput("valid_low_in_done", {63'd0, key_valid}, 64'd0);
            start  = 1'b1;
            key_in = {$urandom, $urandom};
            @(posedge clk); #1;
            start = 1'b0;
            checkOutput("done_one_cycle", {63'd0, done}, 64'd0);
            checkOutput("busy_low_after_done", {63'd0, busy}, 64'd0);
            checkOutput("start_in_done_ignored", {63'd0, key_valid}, 64'd0);
        end
    endtask

    task automatic wait_round(input logic [3:0] target);
        int n;
        n = 0;
        while (round_idx != target && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("reach_round", {60'd0, round_idx}, {60'd0, target});
    endtask

    task automatic check_idle(input string tag);
        checkOutput({tag, "_valid"}, {63'd0, key_valid}, 64'd0);
        checkOutput({tag, "_key_out"}, {16'd0, key_out}, 64'd0);
        checkOutput({tag, "_round_idx"}, {60'd0, round_idx}, 64'd0);
        checkOutput({tag, "_busy"}, {63'd0, busy}, 64'd0);
        checkOutput({tag, "_done"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        start     = 1'b0;
        key_in    = '0;
        decrypt   = 1'b0;
        key_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] encrypt known vector");
        key_ready = 1'b1;
        applyStimulus(KNOWN_KEY, 1'b0, 1);
        wait_done(100, cyc);
        checkOutput("done_latency", cyc, 16);

        $display("[TB] decrypt known vector");
        applyStimulus(KNOWN_KEY, 1'b1, 1);
        wait_done(100, cyc);
        checkOutput("done_latency_dec", cyc, 16);

        $display("[TB] backpressure");
        key_ready = 1'b0;
        applyStimulus(KNOWN_KEY, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("hold_key_out", {16'd0, key_out}, {16'd0, 48'h1B02EFFC7072});
            checkOutput("hold_round_idx", {60'd0, round_idx}, 64'd0);
        end
        key_ready = 1'b1;
        wait_done(100, cyc);

        $display("[TB] start ignored mid-run");
        applyStimulus(KNOWN_KEY, 1'b0, 1);
        wait_round(4'd4);
        start   = 1'b1;
        key_in  = 64'h0;
        decrypt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(100, cyc);

        $display("[TB] reset mid-run");
        applyStimulus(KNOWN_KEY, 1'b0, 1);
        wait_round(4'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("mid_reset");
        sb_q.delete();
        applyStimulus(KNOWN_KEY, 1'b0, 1);
        wait_done(100, cyc);

        $display("[TB] start with reset");
        rst    = 1'b1;
        start  = 1'b1;
        key_in = KNOWN_KEY;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("rst_wins_valid", {63'd0, key_valid}, 64'd0);
        checkOutput("rst_wins_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;

        $display("[TB] parity independence");
        applyStimulus(PAR_KEY, 1'b0, 0);
        wait_done(60, cyc);
        applyStimulus(PAR_KEY ^ 64'h0101010101010101, 1'b0, 0);
        wait_done(60, cyc);

        $display("[TB] random keys");
        for (int t = 0; t < 8; t++) begin
            applyStimulus({$urandom, $urandom}, 1'($urandom_range(1)), 0);
            wait_done(70, cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation timeout");
    end

endmodule
